id_ex_stage: RTL and testbench

- ID/EX pipeline register of the RV32IM pipeline. It sits directly downstream of the instruction-decode controller and the register file.
- Latches the controller's control word together with the operands, PC, immediate and register addresses. Presents them to the EX stage one cycle later.
- Owns load-use hazard detection (stall plus bubble insertion), branch/jump flush, and whole-pipeline hold during memory wait.

---
 rtl/rv_pipe_pkg.sv | 35 +++
 rtl/id_ex_stage_if.sv | 52 +++++
 rtl/id_ex_stage_load_use_detect.sv | 16 +
 rtl/id_ex_stage.sv | 176 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared RV32IM pipeline types: datapath width, control encodings, ID/EX FSM states
// and the NOP control word loaded as a bubble.
package rv_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] BJ_NONE   = 2'b00;
    localparam logic [1:0] BJ_JUMP   = 2'b01;
    localparam logic [1:0] BJ_BRANCH = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } id_ex_state_e;

    typedef struct packed {
        logic [4:0] alu_op;
        logic [1:0] bj_ctrl;
        logic [1:0] wb_sel;
        logic       reg_write_en;
        logic       mem_read_en;
        logic       mem_write_en;
        logic       comp_sel;
        logic       op2_sel;
        logic       op1_sel;
        logic [2:0] func3;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'('0);

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bus: decoded instruction fields in, latched fields out, plus stall/flush and
// an FSM state debug view. master = upstream/test side, slave = the ID/EX stage.
interface id_ex_stage_if #(parameter int XLEN = rv_pipe_pkg::XLEN);
    import rv_pipe_pkg::*;

    logic            VALID_IN,        VALID_OUT;
    logic [4:0]      ALU_OP_IN,       ALU_OP_OUT;
    logic [1:0]      BJ_CTRL_IN,      BJ_CTRL_OUT;
    logic [1:0]      WB_VALUE_SEL_IN, WB_VALUE_SEL_OUT;
    logic            REG_WRITE_EN_IN, REG_WRITE_EN_OUT;
    logic            MEM_READ_EN_IN,  MEM_READ_EN_OUT;
    logic            MEM_WRITE_EN_IN, MEM_WRITE_EN_OUT;
    logic            COMP_SEL_IN,     COMP_SEL_OUT;
    logic            OP2_SEL_IN,      OP2_SEL_OUT;
    logic            OP1_SEL_IN,      OP1_SEL_OUT;
    logic [2:0]      FUNC3_IN,        FUNC3_OUT;
    logic [XLEN-1:0] PC_IN,           PC_OUT;
    logic [XLEN-1:0] DATA1_IN,        DATA1_OUT;
    logic [XLEN-1:0] DATA2_IN,        DATA2_OUT;
    logic [XLEN-1:0] IMM_IN,          IMM_OUT;
    logic [4:0]      RS1_ADDR_IN,     RS1_ADDR_OUT;
    logic [4:0]      RS2_ADDR_IN,     RS2_ADDR_OUT;
    logic [4:0]      RD_ADDR_IN,      RD_ADDR_OUT;
    logic            BRANCH_TAKEN;
    logic            MEM_BUSY;
    logic            STALL_OUT;
    logic            FLUSH_OUT;
    id_ex_state_e    STATE_DBG;

    modport master (
        output VALID_IN, ALU_OP_IN, BJ_CTRL_IN, WB_VALUE_SEL_IN, REG_WRITE_EN_IN,
               MEM_READ_EN_IN, MEM_WRITE_EN_IN, COMP_SEL_IN, OP2_SEL_IN, OP1_SEL_IN,
               FUNC3_IN, PC_IN, DATA1_IN, DATA2_IN, IMM_IN, RS1_ADDR_IN, RS2_ADDR_IN,
               RD_ADDR_IN, BRANCH_TAKEN, MEM_BUSY,
        input  VALID_OUT, ALU_OP_OUT, BJ_CTRL_OUT, WB_VALUE_SEL_OUT, REG_WRITE_EN_OUT,
               MEM_READ_EN_OUT, MEM_WRITE_EN_OUT, COMP_SEL_OUT, OP2_SEL_OUT, OP1_SEL_OUT,
               FUNC3_OUT, PC_OUT, DATA1_OUT, DATA2_OUT, IMM_OUT, RS1_ADDR_OUT, RS2_ADDR_OUT,
               RD_ADDR_OUT, STALL_OUT, FLUSH_OUT, STATE_DBG
    );

    modport slave (
        input  VALID_IN, ALU_OP_IN, BJ_CTRL_IN, WB_VALUE_SEL_IN, REG_WRITE_EN_IN,
               MEM_READ_EN_IN, MEM_WRITE_EN_IN, COMP_SEL_IN, OP2_SEL_IN, OP1_SEL_IN,
               FUNC3_IN, PC_IN, DATA1_IN, DATA2_IN, IMM_IN, RS1_ADDR_IN, RS2_ADDR_IN,
               RD_ADDR_IN, BRANCH_TAKEN, MEM_BUSY,
        output VALID_OUT, ALU_OP_OUT, BJ_CTRL_OUT, WB_VALUE_SEL_OUT, REG_WRITE_EN_OUT,
               MEM_READ_EN_OUT, MEM_WRITE_EN_OUT, COMP_SEL_OUT, OP2_SEL_OUT, OP1_SEL_OUT,
               FUNC3_OUT, PC_OUT, DATA1_OUT, DATA2_OUT, IMM_OUT, RS1_ADDR_OUT, RS2_ADDR_OUT,
               RD_ADDR_OUT, STALL_OUT, FLUSH_OUT, STATE_DBG
    );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard compare between the load sitting in EX and the instruction in ID.
// The rs2 match is deliberately conservative: it ignores whether rs2 is actually read.
module load_use_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    output logic       hazard_o
);

    assign hazard_o = ex_valid_i && ex_mem_read_i && (ex_rd_addr_i != 5'd0) && id_valid_i &&
                      ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble, branch flush and memory-wait hold.
// Optional macro ID_EX_PERF_CNT_EN adds saturating BUBBLE_COUNT / FLUSH_COUNT outputs.
module id_ex_stage
    import rv_pipe_pkg::*;
#(
    parameter int XLEN       = rv_pipe_pkg::XLEN,
    parameter int LU_BUBBLES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0] BUBBLE_COUNT,
    output logic [31:0] FLUSH_COUNT
`endif
);

    // Counter holds the bubbles still owed after the first one.
    localparam logic [1:0] LU_RELOAD = (LU_BUBBLES == 2) ? 2'd1 : 2'd0;

    ctrl_t           ctrl_in, ctrl_q;
    logic            valid_q;
    logic [XLEN-1:0] pc_q, data1_q, data2_q, imm_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    id_ex_state_e    state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            hazard, load_in, load_bub, stall, flush;

    always_comb begin
        ctrl_in              = CTRL_NOP;
        ctrl_in.alu_op       = bus.ALU_OP_IN;
        ctrl_in.bj_ctrl      = bus.BJ_CTRL_IN;
        ctrl_in.wb_sel       = bus.WB_VALUE_SEL_IN;
        ctrl_in.reg_write_en = bus.REG_WRITE_EN_IN;
        ctrl_in.mem_read_en  = bus.MEM_READ_EN_IN;
        ctrl_in.mem_write_en = bus.MEM_WRITE_EN_IN;
        ctrl_in.comp_sel     = bus.COMP_SEL_IN;
        ctrl_in.op2_sel      = bus.OP2_SEL_IN;
        ctrl_in.op1_sel      = bus.OP1_SEL_IN;
        ctrl_in.func3        = bus.FUNC3_IN;
    end

    load_use_detect u_load_use_detect (
        .ex_valid_i   (valid_q),
        .ex_mem_read_i(ctrl_q.mem_read_en),
        .ex_rd_addr_i (rd_q),
        .id_valid_i   (bus.VALID_IN),
        .id_rs1_addr_i(bus.RS1_ADDR_IN),
        .id_rs2_addr_i(bus.RS2_ADDR_IN),
        .hazard_o     (hazard)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_in  = 1'b0;
        load_bub = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        if (bus.MEM_BUSY) begin
            stall = 1'b1;
        end else if (bus.BRANCH_TAKEN) begin
            // Flush abandons any stall in progress.
            flush    = 1'b1;
            load_bub = 1'b1;
            state_d  = ST_RUN;
            cnt_d    = 2'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        load_bub = 1'b1;
                        stall    = 1'b1;
                        cnt_d    = LU_RELOAD;
                        state_d  = (LU_BUBBLES == 2) ? ST_STALL : ST_RUN;
                    end else begin
                        load_in = 1'b1;
                    end
                end
                ST_STALL: begin
                    load_bub = 1'b1;
                    stall    = 1'b1;
                    cnt_d    = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
                    if (cnt_q <= 2'd1) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            pc_q    <= '0;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            rd_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_in) begin
                valid_q <= bus.VALID_IN;
                ctrl_q  <= ctrl_in;
                pc_q    <= bus.PC_IN;
                data1_q <= bus.DATA1_IN;
                data2_q <= bus.DATA2_IN;
                imm_q   <= bus.IMM_IN;
                rs1_q   <= bus.RS1_ADDR_IN;
                rs2_q   <= bus.RS2_ADDR_IN;
                rd_q    <= bus.RD_ADDR_IN;
            end else if (load_bub) begin
                valid_q <= 1'b0;
                ctrl_q  <= CTRL_NOP;
                pc_q    <= '0;
                data1_q <= '0;
                data2_q <= '0;
                imm_q   <= '0;
                rs1_q   <= 5'd0;
                rs2_q   <= 5'd0;
                rd_q    <= 5'd0;
            end
        end
    end

    assign bus.VALID_OUT        = valid_q;
    assign bus.ALU_OP_OUT       = ctrl_q.alu_op;
    assign bus.BJ_CTRL_OUT      = ctrl_q.bj_ctrl;
    assign bus.WB_VALUE_SEL_OUT = ctrl_q.wb_sel;
    assign bus.REG_WRITE_EN_OUT = ctrl_q.reg_write_en;
    assign bus.MEM_READ_EN_OUT  = ctrl_q.mem_read_en;
    assign bus.MEM_WRITE_EN_OUT = ctrl_q.mem_write_en;
    assign bus.COMP_SEL_OUT     = ctrl_q.comp_sel;
    assign bus.OP2_SEL_OUT      = ctrl_q.op2_sel;
    assign bus.OP1_SEL_OUT      = ctrl_q.op1_sel;
    assign bus.FUNC3_OUT        = ctrl_q.func3;
    assign bus.PC_OUT           = pc_q;
    assign bus.DATA1_OUT        = data1_q;
    assign bus.DATA2_OUT        = data2_q;
    assign bus.IMM_OUT          = imm_q;
    assign bus.RS1_ADDR_OUT     = rs1_q;
    assign bus.RS2_ADDR_OUT     = rs2_q;
    assign bus.RD_ADDR_OUT      = rd_q;
    assign bus.STALL_OUT        = stall & ~RESET;
    assign bus.FLUSH_OUT        = flush;
    assign bus.STATE_DBG        = state_q;

`ifdef ID_EX_PERF_CNT_EN
    logic        lu_bubble;
    logic [31:0] bub_cnt_q, fl_cnt_q;

    assign lu_bubble = load_bub & ~flush;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bub_cnt_q <= '0;
            fl_cnt_q  <= '0;
        end else begin
            if (lu_bubble && (bub_cnt_q != 32'hFFFF_FFFF)) bub_cnt_q <= bub_cnt_q + 32'd1;
            if (flush && (fl_cnt_q != 32'hFFFF_FFFF))      fl_cnt_q  <= fl_cnt_q + 32'd1;
        end
    end

    assign BUBBLE_COUNT = bub_cnt_q;
    assign FLUSH_COUNT  = fl_cnt_q;
`else
    // Counters are compiled out; no extra state.
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (1 and 2 load-use bubbles) share one stimulus stream
// and are checked against a per-instance reference model through expected-output queues.
module tb_id_ex_stage;
    import rv_pipe_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [4:0]  alu;
        logic [1:0]  bj;
        logic [1:0]  wb;
        logic        rwe, mre, mwe, comp, op2, op1;
        logic [2:0]  f3;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
    } id_t;

    typedef struct packed {
        id_t  o;
        logic stall;
        logic flush;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    logic clk, rst;
    id_t  drv;
    logic drv_bt, drv_busy;

    logic [EXP_W-1:0] act [2];
    logic [EXP_W-1:0] exp_q [2][$];

    id_t  m_out  [2];
    int   m_left [2];
    int   m_bub  [2];
    int   m_fl   [2];
    bit   last_stall [2];
    bit   last_flush [2];
    exp_t samp [2];

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_stage_if #(.XLEN(32)) if_a [2] ();

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bc [2];
    logic [31:0] fc [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        id_ex_stage #(.XLEN(32), .LU_BUBBLES(g + 1)) u_dut (
            .CLK  (clk),
            .RESET(rst),
            .bus  (if_a[g])
`ifdef ID_EX_PERF_CNT_EN
            ,
            .BUBBLE_COUNT(bc[g]),
            .FLUSH_COUNT (fc[g])
`endif
        );

        assign if_a[g].VALID_IN        = drv.valid;
        assign if_a[g].ALU_OP_IN       = drv.alu;
        assign if_a[g].BJ_CTRL_IN      = drv.bj;
        assign if_a[g].WB_VALUE_SEL_IN = drv.wb;
        assign if_a[g].REG_WRITE_EN_IN = drv.rwe;
        assign if_a[g].MEM_READ_EN_IN  = drv.mre;
        assign if_a[g].MEM_WRITE_EN_IN = drv.mwe;
        assign if_a[g].COMP_SEL_IN     = drv.comp;
        assign if_a[g].OP2_SEL_IN      = drv.op2;
        assign if_a[g].OP1_SEL_IN      = drv.op1;
        assign if_a[g].FUNC3_IN        = drv.f3;
        assign if_a[g].PC_IN           = drv.pc;
        assign if_a[g].DATA1_IN        = drv.d1;
        assign if_a[g].DATA2_IN        = drv.d2;
        assign if_a[g].IMM_IN          = drv.imm;
        assign if_a[g].RS1_ADDR_IN     = drv.rs1;
        assign if_a[g].RS2_ADDR_IN     = drv.rs2;
        assign if_a[g].RD_ADDR_IN      = drv.rd;
        assign if_a[g].BRANCH_TAKEN    = drv_bt;
        assign if_a[g].MEM_BUSY        = drv_busy;

        assign act[g] = {if_a[g].VALID_OUT, if_a[g].ALU_OP_OUT, if_a[g].BJ_CTRL_OUT,
                         if_a[g].WB_VALUE_SEL_OUT, if_a[g].REG_WRITE_EN_OUT,
                         if_a[g].MEM_READ_EN_OUT, if_a[g].MEM_WRITE_EN_OUT,
                         if_a[g].COMP_SEL_OUT, if_a[g].OP2_SEL_OUT, if_a[g].OP1_SEL_OUT,
                         if_a[g].FUNC3_OUT, if_a[g].PC_OUT, if_a[g].DATA1_OUT,
                         if_a[g].DATA2_OUT, if_a[g].IMM_OUT, if_a[g].RS1_ADDR_OUT,
                         if_a[g].RS2_ADDR_OUT, if_a[g].RD_ADDR_OUT,
                         if_a[g].STALL_OUT, if_a[g].FLUSH_OUT};
    end

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the EX register is either the ID word, a NOP, or unchanged;
    // m_left counts the load-use bubbles still owed.
    task automatic model_step(input int k, input id_t in, input bit bt, input bit busy,
                              input bit r, output bit st, output bit fl);
        exp_t e;
        bit   hz;
        if (r) begin
            m_out[k]  = '0;
            m_left[k] = 0;
            m_bub[k]  = 0;
            m_fl[k]   = 0;
        end
        hz = m_out[k].valid && m_out[k].mre && (m_out[k].rd != 0) && in.valid &&
             ((m_out[k].rd == in.rs1) || (m_out[k].rd == in.rs2));
        st = 1'b0;
        fl = 1'b0;
        if (busy)                        st = 1'b1;
        else if (bt)                     fl = 1'b1;
        else if (m_left[k] > 0 || hz)    st = 1'b1;
        if (r) st = 1'b0;
        e.o     = m_out[k];
        e.stall = st;
        e.flush = fl;
        exp_q[k].push_back(e);
        if (!r && !busy) begin
            if (bt) begin
                m_out[k] = '0; m_left[k] = 0; m_fl[k]++;
            end else if (m_left[k] > 0) begin
                m_out[k] = '0; m_left[k]--; m_bub[k]++;
            end else if (hz) begin
                m_out[k] = '0; m_left[k] = (k + 1) - 1; m_bub[k]++;
            end else begin
                m_out[k] = in;
            end
        end
    endtask

    // Driver tasks
    task automatic drive_cycle(input id_t in, input bit bt, input bit busy, input bit r);
        bit st, fl;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) samp[k] = exp_t'(act[k]);
        drv      = in;
        drv_bt   = bt;
        drv_busy = busy;
        rst      = r;
        for (int k = 0; k < 2; k++) begin
            model_step(k, in, bt, busy, r, st, fl);
            last_stall[k] = st;
            last_flush[k] = fl;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Hold an instruction in ID while either instance stalls, as IF/ID would.
    task automatic issue(input id_t in, output int s0, output int s1);
        int n;
        n  = 0;
        s0 = 0;
        s1 = 0;
        do begin
            drive_cycle(in, 1'b0, 1'b0, 1'b0);
            s0 += int'(last_stall[0]);
            s1 += int'(last_stall[1]);
            n++;
        end while ((last_stall[0] || last_stall[1]) && n < 8);
        if (n >= 8) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_bound: stall still asserted after %0d cycles", n);
        end
    endtask

    function automatic id_t mk_ins(input logic [4:0] alu, input logic mre, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [31:0] pc);
        id_t t;
        t.valid = 1'b1;
        t.alu   = alu;
        t.bj    = BJ_NONE;
        t.wb    = mre ? WB_SEL_MEM : WB_SEL_ALU;
        t.rwe   = 1'b1;
        t.mre   = mre;
        t.mwe   = 1'b0;
        t.comp  = 1'b0;
        t.op2   = mre;
        t.op1   = 1'b0;
        t.f3    = mre ? 3'b010 : 3'b000;
        t.pc    = pc;
        t.d1    = $urandom;
        t.d2    = $urandom;
        t.imm   = mre ? 32'h4 : 32'h0;
        t.rs1   = rs1;
        t.rs2   = rs2;
        t.rd    = rd;
        return t;
    endfunction

    function automatic id_t rand_ins();
        id_t t;
        t.valid = ($urandom_range(0, 4) != 0);
        t.alu   = 5'($urandom);
        t.bj    = 2'($urandom_range(0, 2));
        t.wb    = 2'($urandom_range(0, 2));
        t.rwe   = 1'($urandom);
        t.mre   = ($urandom_range(0, 2) == 0);
        t.mwe   = 1'($urandom);
        t.comp  = 1'($urandom);
        t.op2   = 1'($urandom);
        t.op1   = 1'($urandom);
        t.f3    = 3'($urandom);
        t.pc    = $urandom;
        t.d1    = $urandom;
        t.d2    = $urandom;
        t.imm   = $urandom;
        t.rs1   = 5'($urandom_range(0, 3));
        t.rs2   = 5'($urandom_range(0, 3));
        t.rd    = 5'($urandom_range(0, 3));
        return t;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (exp_q[k].size() != 0) begin
                logic [EXP_W-1:0] e;
                e = exp_q[k].pop_front();
                n_cmp++;
                if (act[k] !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard dut%0d t=%0t: got %h expected %h", k, $time, act[k], e);
                end
            end
        end
    end

    initial begin
        id_t nop, cur;
        int  s0, s1;
        nop      = '0;
        drv      = '0;
        drv_bt   = 1'b0;
        drv_busy = 1'b0;
        rst      = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_out[k] = '0; m_left[k] = 0; m_bub[k] = 0; m_fl[k] = 0;
            last_stall[k] = 1'b0; last_flush[k] = 1'b0;
        end

        drive_cycle(nop, 1'b0, 1'b0, 1'b1);
        drive_cycle(nop, 1'b0, 1'b0, 1'b1);
        drive_cycle(nop, 1'b0, 1'b0, 1'b0);
        check("reset_valid", {31'd0, samp[0].o.valid}, 32'd0);

        // Load-use: LW x5 then ADD x6,x5,x1
        issue(mk_ins(5'd0, 1'b1, 5'd5, 5'd2, 5'd0, 32'h100), s0, s1);
        issue(mk_ins(5'd0, 1'b0, 5'd6, 5'd5, 5'd1, 32'h104), s0, s1);
        check("lu1_stall_cycles", s0, 1);
        check("lu2_stall_cycles", s1, 2);
        drive_cycle(nop, 1'b0, 1'b0, 1'b0);
        check("lu1_add_rs1", {27'd0, samp[0].o.rs1}, 32'd5);
        check("lu2_add_rs1", {27'd0, samp[1].o.rs1}, 32'd5);

        // Load to x0 never stalls
        issue(mk_ins(5'd0, 1'b1, 5'd0, 5'd2, 5'd0, 32'h110), s0, s1);
        issue(mk_ins(5'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'h114), s0, s1);
        check("x0_stall_lu1", s0, 0);
        check("x0_stall_lu2", s1, 0);

        // Flush beats a simultaneous hazard
        issue(mk_ins(5'd0, 1'b1, 5'd7, 5'd2, 5'd0, 32'h120), s0, s1);
        drive_cycle(mk_ins(5'd0, 1'b0, 5'd8, 5'd7, 5'd1, 32'h124), 1'b1, 1'b0, 1'b0);
        check("flush_wins_stall", {31'd0, last_stall[0]}, 32'd0);
        check("flush_wins_flush", {31'd0, last_flush[0]}, 32'd1);
        drive_cycle(nop, 1'b0, 1'b0, 1'b0);
        check("flush_bubble_valid", {31'd0, samp[1].o.valid}, 32'd0);

        // Memory hold with a pending branch
        issue(mk_ins(5'b10000, 1'b0, 5'd9, 5'd3, 5'd4, 32'h200), s0, s1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(mk_ins(5'd0, 1'b0, 5'd10, 5'd1, 5'd2, 32'h204), 1'b1, 1'b1, 1'b0);
            check("hold_alu_op", {27'd0, samp[0].o.alu}, 32'h10);
            check("hold_stall", {31'd0, last_stall[0]}, 32'd1);
            check("hold_flush", {31'd0, last_flush[0]}, 32'd0);
        end
        drive_cycle(mk_ins(5'd0, 1'b0, 5'd10, 5'd1, 5'd2, 32'h204), 1'b1, 1'b0, 1'b0);
        check("release_flush", {31'd0, last_flush[0]}, 32'd1);
        drive_cycle(nop, 1'b0, 1'b0, 1'b0);
        check("release_bubble", {31'd0, samp[0].o.valid}, 32'd0);

        // Reset in the middle of the two-bubble stall
        issue(mk_ins(5'd0, 1'b1, 5'd5, 5'd2, 5'd0, 32'h300), s0, s1);
        drive_cycle(mk_ins(5'd0, 1'b0, 5'd6, 5'd5, 5'd1, 32'h304), 1'b0, 1'b0, 1'b0);
        drive_cycle(mk_ins(5'd0, 1'b0, 5'd6, 5'd5, 5'd1, 32'h304), 1'b0, 1'b1, 1'b1);
        #1;
        check("rst_async_stall", {31'd0, if_a[1].STALL_OUT}, 32'd0);
        check("rst_async_state", {31'd0, if_a[1].STATE_DBG}, 32'd0);
        drive_cycle(nop, 1'b0, 1'b0, 1'b0);
        drive_cycle(mk_ins(5'd0, 1'b0, 5'd6, 5'd1, 5'd2, 32'h10), 1'b0, 1'b0, 1'b0);
        drive_cycle(nop, 1'b0, 1'b0, 1'b0);
        check("post_rst_pc_lu1", samp[0].o.pc, 32'h10);
        check("post_rst_pc_lu2", samp[1].o.pc, 32'h10);

        // Randomized traffic
        cur = rand_ins();
        for (int i = 0; i < 400; i++) begin
            bit bt, busy, r;
            bt   = ($urandom_range(0, 9) == 0);
            busy = ($urandom_range(0, 9) == 0);
            r    = ($urandom_range(0, 99) == 0);
            if (!(last_stall[0] || last_stall[1]) || last_flush[0]) cur = rand_ins();
            drive_cycle(cur, bt, busy, r);
        end

        drive_cycle(nop, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
`ifdef ID_EX_PERF_CNT_EN
        for (int k = 0; k < 2; k++) begin
            check("bubble_count", bc[k], m_bub[k]);
            check("flush_count", fc[k], m_fl[k]);
        end
`endif
        @(negedge clk);
        #1;
        check("queue0_drained", exp_q[0].size(), 0);
        check("queue1_drained", exp_q[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
